// File: rtl/wb_mon_pkg.sv
// rtl/wb_mon_pkg.sv - shared constants and helpers for the write-back trace monitor
package wb_mon_pkg;

   localparam int DEF_NCH = 2;
   localparam int DEF_DW  = 32;
   localparam int DEF_AW  = 5;
   localparam int DEF_TSW = 16;
   localparam int CHW     = 2;

   // Trace entry layout, MSB first: {channel, address, data, timestamp}
   function automatic int entry_w(input int aw, input int dw, input int tsw);
      return CHW + aw + dw + tsw;
   endfunction

   localparam int ENTRY_W = CHW + DEF_AW + DEF_DW + DEF_TSW;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/wb_trace_fifo.sv
// rtl/wb_trace_fifo.sv - multi-push, single-pop trace FIFO
// A pop on the same edge frees its slot for that edge's pushes.
module wb_trace_fifo
   import wb_mon_pkg::*;
#(
   parameter int NCH   = DEF_NCH,
   parameter int DEPTH = 8,
   parameter int EW    = ENTRY_W
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NCH-1:0]          push_i,
   input  logic [NCH*EW-1:0]       push_data_i,
   input  logic                    pop_i,
   output logic [EW-1:0]           head_o,
   output logic [clog2(DEPTH):0]   level_o,
   output logic [clog2(DEPTH):0]   free_o
);
   localparam int PW = clog2(DEPTH);
   localparam int LW = PW + 1;

   logic [EW-1:0]  mem_q [DEPTH];
   logic [PW-1:0]  rd_q, rd_d, wr_q, wr_d;
   logic [LW-1:0]  level_q, level_d, nacc;
   logic [NCH-1:0] wen;
   logic [PW-1:0]  waddr [NCH];
   logic           pop;

   assign pop    = pop_i && (level_q != '0);
   assign free_o = LW'(DEPTH) - level_q + LW'(pop);

   // Accepted pushes are packed into consecutive slots in channel order
   always_comb begin
      nacc = '0;
      for (int c = 0; c < NCH; c++) begin
         wen[c]   = 1'b0;
         waddr[c] = wr_q + PW'(nacc);
         if (push_i[c] && (nacc < free_o)) begin
            wen[c] = 1'b1;
            nacc   = nacc + LW'(1);
         end
      end
      level_d = level_q + nacc - LW'(pop);
      wr_d    = wr_q + PW'(nacc);
      rd_d    = rd_q + PW'(pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q    <= '0;
         wr_q    <= '0;
         level_q <= '0;
      end else begin
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         level_q <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      for (int c = 0; c < NCH; c++)
         if (wen[c]) mem_q[waddr[c]] <= push_data_i[c*EW +: EW];
   end

   assign head_o  = (level_q != '0) ? mem_q[rd_q] : '0;
   assign level_o = level_q;

endmodule

// File: rtl/wb_trace_monitor.sv
// rtl/wb_trace_monitor.sv - write-back monitor with shadow register file and trace FIFO
module wb_trace_monitor
   import wb_mon_pkg::*;
#(
   parameter int NCH      = DEF_NCH,
   parameter int DW       = DEF_DW,
   parameter int AW       = DEF_AW,
   parameter int PCW      = 32,
   parameter int PC_START = 12,
   parameter int DEPTH    = 8,
   parameter int TSW      = DEF_TSW,
   parameter int ZERO_REG = 1
)(
   input  logic                    reloj,
   input  logic                    resetM,
   input  logic [PCW-1:0]          pc,
   input  logic [NCH-1:0]          wr_n,
   input  logic [NCH*AW-1:0]       wr_addr,
   input  logic [NCH*DW-1:0]       wr_data,
   input  logic [AW-1:0]           rd_addr,
   output logic [DW-1:0]           rd_data,
   output logic                    trace_valid,
   input  logic                    trace_ready,
   output logic [1:0]              trace_ch,
   output logic [AW-1:0]           trace_addr,
   output logic [DW-1:0]           trace_data,
   output logic [TSW-1:0]          trace_ts,
   output logic [clog2(DEPTH):0]   fifo_level,
   output logic [7:0]              ovf_count,
   output logic                    conflict
);
   localparam int EW = entry_w(AW, DW, TSW);
   localparam int LW = clog2(DEPTH) + 1;

   logic [TSW-1:0]    ts_q, ts_d;
   logic [7:0]        ovf_q, ovf_d;
   logic              conflict_q, conflict_d;
   logic [DW-1:0]     shadow_q [2**AW];
   logic [DW-1:0]     shadow_d [2**AW];
   logic [NCH-1:0]    qual;
   logic [NCH*EW-1:0] push_data;
   logic [EW-1:0]     head;
   logic [LW-1:0]     free;
   logic [LW-1:0]     level;
   logic [LW-1:0]     npush;
   logic [LW-1:0]     dropped;
   logic [8:0]        ovf_sum;

   assign qual = (pc >= PCW'(PC_START)) ? ~wr_n : '0;

   // Ascending channel order: the highest channel wins an address collision
   always_comb begin
      shadow_d   = shadow_q;
      conflict_d = 1'b0;
      npush      = '0;
      push_data  = '0;
      for (int c = 0; c < NCH; c++) begin
         push_data[c*EW +: EW] = {2'(c), wr_addr[c*AW +: AW], wr_data[c*DW +: DW], ts_q};
         if (qual[c]) begin
            npush = npush + LW'(1);
            if (ZERO_REG == 0 || wr_addr[c*AW +: AW] != '0)
               shadow_d[wr_addr[c*AW +: AW]] = wr_data[c*DW +: DW];
            for (int b = 0; b < c; b++)
               if (qual[b] && (wr_addr[b*AW +: AW] == wr_addr[c*AW +: AW]))
                  conflict_d = 1'b1;
         end
      end
      dropped = (npush > free) ? (npush - free) : '0;
      ovf_sum = {1'b0, ovf_q} + 9'(dropped);
      ovf_d   = ovf_sum[8] ? 8'hFF : ovf_sum[7:0];
      ts_d    = ts_q + TSW'(1);
   end

   always_ff @(posedge reloj or negedge resetM) begin
      if (!resetM) begin
         ts_q       <= '0;
         ovf_q      <= '0;
         conflict_q <= 1'b0;
         for (int i = 0; i < 2**AW; i++) shadow_q[i] <= '0;
      end else begin
         ts_q       <= ts_d;
         ovf_q      <= ovf_d;
         conflict_q <= conflict_d;
         shadow_q   <= shadow_d;
      end
   end

   wb_trace_fifo #(
      .NCH   (NCH),
      .DEPTH (DEPTH),
      .EW    (EW)
   ) u_fifo (
      .clk         (reloj),
      .rst_n       (resetM),
      .push_i      (qual),
      .push_data_i (push_data),
      .pop_i       (trace_ready),
      .head_o      (head),
      .level_o     (level),
      .free_o      (free)
   );

   assign rd_data = shadow_q[rd_addr];
   assign {trace_ch, trace_addr, trace_data, trace_ts} = head;
   assign trace_valid = (level != '0);
   assign fifo_level  = level;
   assign ovf_count   = ovf_q;
   assign conflict    = conflict_q;

endmodule

// File: tb/tb_wb_trace_monitor.sv
// tb/tb_wb_trace_monitor.sv - directed plus randomized bench for wb_trace_monitor
module tb_wb_trace_monitor;
   localparam int NCH      = 2;
   localparam int DW       = 32;
   localparam int AW       = 5;
   localparam int PCW      = 32;
   localparam int PC_START = 12;
   localparam int DEPTH    = 8;
   localparam int TSW      = 16;

   logic              reloj = 1'b0;
   logic              resetM;
   logic [PCW-1:0]    pc;
   logic [NCH-1:0]    wr_n;
   logic [NCH*AW-1:0] wr_addr;
   logic [NCH*DW-1:0] wr_data;
   logic [AW-1:0]     rd_addr;
   logic [DW-1:0]     rd_data;
   logic              trace_valid;
   logic              trace_ready;
   logic [1:0]        trace_ch;
   logic [AW-1:0]     trace_addr;
   logic [DW-1:0]     trace_data;
   logic [TSW-1:0]    trace_ts;
   logic [3:0]        fifo_level;
   logic [7:0]        ovf_count;
   logic              conflict;

   wb_trace_monitor #(
      .NCH(NCH), .DW(DW), .AW(AW), .PCW(PCW), .PC_START(PC_START),
      .DEPTH(DEPTH), .TSW(TSW), .ZERO_REG(1)
   ) dut (
      .reloj(reloj), .resetM(resetM), .pc(pc), .wr_n(wr_n),
      .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data),
      .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_ch(trace_ch),
      .trace_addr(trace_addr), .trace_data(trace_data), .trace_ts(trace_ts),
      .fifo_level(fifo_level), .ovf_count(ovf_count), .conflict(conflict)
   );

   always #5 reloj = ~reloj;

   typedef struct {
      int             ch;
      logic [AW-1:0]  addr;
      logic [DW-1:0]  data;
      logic [TSW-1:0] ts;
   } ev_t;

   ev_t            mq[$];
   logic [DW-1:0]  msh [32];
   int             movf;
   logic [TSW-1:0] mts;
   logic           mconf;
   int             checks = 0;
   int             failures = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      for (int i = 0; i < 32; i++) msh[i] = '0;
      movf  = 0;
      mts   = '0;
      mconf = 1'b0;
   endtask

   // One clock edge of the reference: pop first, then accept writes while room remains
   task automatic model_edge();
      int  pop;
      int  free;
      int  pushes;
      ev_t e;
      pop    = (mq.size() > 0 && trace_ready) ? 1 : 0;
      free   = DEPTH - mq.size() + pop;
      if (pop != 0) void'(mq.pop_front());
      mconf  = 1'b0;
      pushes = 0;
      if (pc >= PC_START) begin
         for (int c = 0; c < NCH; c++) begin
            if (!wr_n[c]) begin
               e.ch   = c;
               e.addr = wr_addr[c*AW +: AW];
               e.data = wr_data[c*DW +: DW];
               e.ts   = mts;
               if (pushes < free) mq.push_back(e);
               else if (movf < 255) movf++;
               pushes++;
               if (e.addr != 0) msh[e.addr] = e.data;
               for (int b = 0; b < c; b++)
                  if (!wr_n[b] && wr_addr[b*AW +: AW] == e.addr) mconf = 1'b1;
            end
         end
      end
      mts = mts + 16'd1;
   endtask

   task automatic check_all();
      chk("valid", trace_valid, mq.size() > 0);
      chk("level", fifo_level, mq.size());
      chk("ovf", ovf_count, movf);
      chk("conflict", conflict, mconf);
      chk("rd_data", rd_data, msh[rd_addr]);
      if (mq.size() > 0) begin
         chk("head_ch", trace_ch, mq[0].ch);
         chk("head_addr", trace_addr, mq[0].addr);
         chk("head_data", trace_data, mq[0].data);
         chk("head_ts", trace_ts, mq[0].ts);
      end else begin
         chk("head_zero", {trace_ch, trace_addr, trace_data, trace_ts}, 0);
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge reloj);
      #1;
      check_all();
   endtask

   task automatic set_wr(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_addr[c*AW +: AW] = a;
      wr_data[c*DW +: DW] = d;
   endtask

   initial begin
      pc = '0; wr_n = '1; wr_addr = '0; wr_data = '0; rd_addr = '0;
      trace_ready = 1'b0; resetM = 1'b0;
      model_reset();
      repeat (3) @(posedge reloj);
      #1;
      check_all();

      // Gating: pc below PC_START
      resetM = 1'b1;
      pc = 8; wr_n = 2'b10; set_wr(0, 5'd3, 32'hAAAA0001); rd_addr = 5'd3;
      tick();
      chk("gate_no_push", fifo_level, 0);
      chk("gate_rd3", rd_data, 0);
      pc = 12;
      tick();
      chk("first_valid", trace_valid, 1);
      chk("first_ch", trace_ch, 0);
      chk("first_addr", trace_addr, 3);
      chk("first_data", trace_data, 32'hAAAA0001);
      chk("first_rd3", rd_data, 32'hAAAA0001);
      wr_n = '1; trace_ready = 1'b1;
      tick();
      trace_ready = 1'b0;

      // Dual write to the same address
      pc = 20; wr_n = 2'b00; set_wr(0, 5'd7, 32'h11); set_wr(1, 5'd7, 32'h22); rd_addr = 5'd7;
      tick();
      chk("dual_conflict", conflict, 1);
      chk("dual_rd7", rd_data, 32'h22);
      chk("dual_level", fifo_level, 2);
      chk("dual_head0", trace_data, 32'h11);
      wr_n = '1;
      tick();
      chk("dual_conflict_clr", conflict, 0);
      trace_ready = 1'b1;
      tick();
      chk("dual_head1_ch", trace_ch, 1);
      chk("dual_head1_data", trace_data, 32'h22);
      chk("dual_ts_equal", trace_ts, TSW'(mts - 16'd3));
      tick();
      trace_ready = 1'b0;

      // Zero register write is traced but not stored
      wr_n = 2'b01; set_wr(1, 5'd0, 32'hFFFFFFFF); rd_addr = 5'd0;
      tick();
      chk("zero_addr", trace_addr, 0);
      chk("zero_data", trace_data, 32'hFFFFFFFF);
      chk("zero_rd0", rd_data, 0);
      wr_n = '1; trace_ready = 1'b1;
      tick();
      trace_ready = 1'b0;

      // Overflow: 10 events into 8 slots
      for (int i = 0; i < 5; i++) begin
         wr_n = 2'b00;
         set_wr(0, AW'($urandom_range(1, 31)), $urandom);
         set_wr(1, AW'($urandom_range(1, 31)), $urandom);
         rd_addr = AW'($urandom_range(0, 31));
         tick();
      end
      chk("ovf_level", fifo_level, 8);
      chk("ovf_count", ovf_count, 2);

      // Full with simultaneous pop
      trace_ready = 1'b1; wr_n = 2'b10; set_wr(0, 5'd9, 32'hC0FFEE00);
      tick();
      chk("fullpop_level", fifo_level, 8);
      chk("fullpop_ovf", ovf_count, 2);
      wr_n = '1;
      repeat (3) tick();
      chk("drain_level5", fifo_level, 5);

      // Asynchronous reset mid-drain
      #3;
      resetM = 1'b0;
      #1;
      chk("rst_async_valid", trace_valid, 0);
      chk("rst_async_level", fifo_level, 0);
      chk("rst_async_ovf", ovf_count, 0);
      model_reset();
      #2;
      resetM = 1'b1;
      trace_ready = 1'b0; pc = 40; wr_n = 2'b10; set_wr(0, 5'd1, 32'h5A5A5A5A);
      tick();
      chk("ts_restart", trace_ts, 0);

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         pc          = PCW'($urandom_range(0, 30));
         wr_n        = NCH'($urandom);
         set_wr(0, AW'($urandom_range(0, 3)), $urandom);
         set_wr(1, AW'($urandom_range(0, 3)), $urandom);
         trace_ready = ($urandom_range(0, 2) == 0);
         rd_addr     = AW'($urandom_range(0, 3));
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
